// File: rtl/ram_arbiter.sv
// ram_arbiter: clears the display RAM after reset or on command, then shares it round-robin between two requesters.
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    typedef enum logic {CLEAR, SERVE} state_t;
    state_t        state;
    logic [AW:0]   cnt;
    logic          rr, rd0, rd1;
    logic          el0, el1, win0, win1;
    // A port granted at the previous edge is masked, so one requester gets at most every other cycle
    assign el0   = req0 && !gnt0;
    assign el1   = req1 && !gnt1;
    assign win0  = (state == SERVE) && !clr_req && el0 && (!el1 || !rr);
    assign win1  = (state == SERVE) && !clr_req && el1 && (!el0 || rr);
    assign rdata = ram_dout;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            rr       <= 1'b0;
            rd0      <= 1'b0;
            rd1      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            busy     <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            gnt0    <= win0;
            gnt1    <= win1;
            rd0     <= win0 && !we0;
            rd1     <= win1 && !we1;
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            // Counter MSB flags the end of the sweep, so the last address is written exactly once
            if (state == CLEAR) begin
                if (cnt[AW]) begin
                    state  <= SERVE;
                    busy   <= 1'b0;
                    ram_we <= 1'b0;
                end else begin
                    ram_we   <= 1'b1;
                    ram_addr <= cnt[AW-1:0];
                    ram_din  <= '0;
                    cnt      <= cnt + 1'b1;
                end
            end else if (clr_req) begin
                state  <= CLEAR;
                busy   <= 1'b1;
                cnt    <= '0;
                ram_we <= 1'b0;
            end else if (win0 || win1) begin
                ram_we   <= win0 ? we0 : we1;
                ram_addr <= win0 ? addr0 : addr1;
                ram_din  <= win0 ? wdata0 : wdata1;
                rr       <= win0;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors and clear/reset sequences for ram_arbiter against a synchronous RAM model.
module tb_ram_arbiter;
    logic        clk = 1'b0, rst = 1'b0, clr_req = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0, ram_addr;
    logic [15:0] wdata0 = '0, wdata1 = '0, rdata, ram_din, ram_dout;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [15:0] mem [256];
    int          checks = 0, failures = 0;

    typedef struct {
        logic r0, w0; logic [7:0] a0; logic [15:0] d0;
        logic r1, w1; logic [7:0] a1; logic [15:0] d1;
        logic g0, g1, we; logic [7:0] a; logic [15:0] d;
        logic v0, v1; logic [15:0] rd;
    } vec_t;
    vec_t vt[$];

    ram_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, input logic [15:0] d0,
                                input logic r1, w1, input logic [7:0] a1, input logic [15:0] d1,
                                input logic g0, g1, we, input logic [7:0] a, input logic [15:0] d,
                                input logic v0, v1, input logic [15:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.a = a; v.d = d; v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects CLEAR with counter 0; each following edge must write zero to the next address
    task automatic sweep(input int clr_at, input int rst_at, input int req_at);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            clr_req = (i == clr_at);
            if (i == req_at) req0 = 1'b1;
            step();
            if (bad == 0 && !(ram_we === 1'b1 && busy === 1'b1 && ram_addr === i[7:0] && ram_din === 16'h0)) begin
                bad = 1;
                $display("FAIL sweep[%0d] we=%b busy=%b addr=%h din=%h want we=1 busy=1 addr=%h din=0",
                         i, ram_we, busy, ram_addr, ram_din, i[7:0]);
            end
            if (i == rst_at) begin
                checks++;
                failures += bad;
                #1 rst = 1'b0;
                #1 chk("async_reset", {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy, ram_addr, ram_din},
                       {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000});
                #1 rst = 1'b1;
                return;
            end
        end
        clr_req = 1'b0;
        checks++;
        failures += bad;
        step();
        chk("sweep_end", {ram_we, busy, gnt0, gnt1}, 4'b0000);
    endtask

    initial begin
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'hFF,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(1,1,8'h12,16'hBEEF, 0,0,8'h00,16'h0000, 1,0,1,8'h12,16'hBEEF, 0,0,16'h0000));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h12,16'hBEEF, 0,0,16'h0000));
        vt.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 0,1,0,8'h12,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h12,16'h0000, 0,1,16'hBEEF));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h12,16'h0000, 0,0,16'h0000));
        for (int k = 0; k < 8; k++)
            vt.push_back(k % 2 == 0 ?
                mk(1,1,8'h20,16'h1111, 1,1,8'h21,16'h2222, 1,0,1,8'h20,16'h1111, 0,0,16'h0000) :
                mk(1,1,8'h20,16'h1111, 1,1,8'h21,16'h2222, 0,1,1,8'h21,16'h2222, 0,0,16'h0000));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h21,16'h2222, 0,0,16'h0000));
        vt.push_back(mk(1,0,8'h20,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h20,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(1,0,8'h20,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h20,16'h0000, 1,0,16'h1111));
        vt.push_back(mk(1,0,8'h20,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h20,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(1,0,8'h20,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h20,16'h0000, 1,0,16'h1111));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h20,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(1,0,8'h21,16'h0000, 1,1,8'h30,16'h3333, 0,1,1,8'h30,16'h3333, 0,0,16'h0000));
        vt.push_back(mk(1,0,8'h21,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,8'h21,16'h0000, 0,0,16'h0000));
        vt.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,8'h21,16'h0000, 1,0,16'h2222));

        #12 chk("reset_state", {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy, ram_addr, ram_din},
                {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000});
        #2 rst = 1'b1;
        sweep(-1, -1, -1);

        foreach (vt[k]) begin
            req0 = vt[k].r0; we0 = vt[k].w0; addr0 = vt[k].a0; wdata0 = vt[k].d0;
            req1 = vt[k].r1; we1 = vt[k].w1; addr1 = vt[k].a1; wdata1 = vt[k].d1;
            step();
            chk($sformatf("vec%0d", k), {gnt0, gnt1, ram_we, ram_addr, ram_din, rvalid0, rvalid1},
                {vt[k].g0, vt[k].g1, vt[k].we, vt[k].a, vt[k].d, vt[k].v0, vt[k].v1});
            if (vt[k].v0 || vt[k].v1) chk($sformatf("vec%0d_rdata", k), rdata, vt[k].rd);
        end
        req0 = 1'b0; req1 = 1'b0;

        // clr_req right after a port 1 read grant: the read still completes
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
        step();
        chk("clr_rd_gnt", {gnt1, ram_addr}, {1'b1, 8'h30});
        req1 = 1'b0; clr_req = 1'b1;
        step();
        chk("clr_rvalid", {rvalid1, rdata, busy, ram_we}, {1'b1, 16'h3333, 1'b1, 1'b0});
        clr_req = 1'b0; we0 = 1'b1; addr0 = 8'h55; wdata0 = 16'hABCD;
        sweep(-1, -1, 100);
        step();
        chk("first_serve_gnt", {gnt0, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 8'h55, 16'hABCD});
        req0 = 1'b0;
        step();

        // Grant suppressed in the clr_req cycle; clr_req during CLEAR ignored
        clr_req = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h55;
        step();
        chk("clr_suppress", {gnt0, busy, ram_we}, {1'b0, 1'b1, 1'b0});
        clr_req = 1'b0;
        sweep(100, -1, -1);
        step();
        chk("pending_gnt", {gnt0, ram_we, ram_addr}, {1'b1, 1'b0, 8'h55});
        req0 = 1'b0;
        step();
        chk("cleared_read", {rvalid0, rdata}, {1'b1, 16'h0000});

        // Reset mid-sweep at address 0x40, then a full restart
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        sweep(-1, 'h40, -1);
        sweep(-1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
